ram_tdp_fifo: RTL and testbench
===============================

RAM_TDP_FIFO -- requirements
Module: ram_tdp_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the data word width.
REQ-002 The block SHALL have parameter ADDR_W, default 6, giving the RAM address width.
REQ-003 The block SHALL have parameter DEPTH, default 64 (2**ADDR_W), giving the number of FIFO entries.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port wr_en, input, 1 bit: push request.
REQ-007 The block SHALL have port wr_data, input, DATA_W bits: push data.
REQ-008 The block SHALL have port rd_en, input, 1 bit: pop request.
REQ-009 The block SHALL have port rd_data, output, DATA_W bits: popped word, registered.
REQ-010 The block SHALL have port rd_valid, output, 1 bit: rd_data holds a newly popped word this cycle.
REQ-011 The block SHALL have port full, output, 1 bit: count == DEPTH.
REQ-012 The block SHALL have port empty, output, 1 bit: count == 0.
REQ-013 The block SHALL have port count, output, ADDR_W+1 bits: current occupancy, 0..DEPTH.
REQ-014 The block SHALL have port overflow, output, 1 bit: one-cycle pulse on a rejected push.
REQ-015 The block SHALL have port underflow, output, 1 bit: one-cycle pulse on a rejected pop.

Function
REQ-016 A push SHALL be accepted when wr_en=1 and (full=0, or rd_en=1 with full=1); an accepted push writes wr_data at wr_ptr and increments wr_ptr.
REQ-017 A pop SHALL be accepted when rd_en=1 and empty=0; an accepted pop reads at rd_ptr and increments rd_ptr.
REQ-018 rd_data SHALL present the popped word exactly one cycle after acceptance, with rd_valid=1 in that cycle only; rd_data holds its value otherwise.
REQ-019 Pointers SHALL wrap from DEPTH-1 to 0 with no gap or skipped entry.
REQ-020 count SHALL be +1 on a push alone, -1 on a pop alone, and unchanged on a simultaneous push and pop; full and empty SHALL be registered and consistent with count every cycle.
REQ-021 A simultaneous push and pop when empty SHALL accept only the push: underflow=1, count becomes 1, rd_valid=0 next cycle.
REQ-022 A simultaneous push and pop when full SHALL accept both; the read at rd_ptr == wr_ptr SHALL return the old stored word (read-first), and count stays DEPTH.
REQ-023 A push with full=1 and rd_en=0 SHALL be dropped, with overflow=1 for one cycle and state unchanged.
REQ-024 A pop with empty=1 SHALL be dropped, with underflow=1 for one cycle and rd_valid=0.
REQ-025 Data SHALL leave in strict push order; no word is duplicated or lost across wrap.

Reset
REQ-026 While rst_n=0 at a clk edge, wr_ptr, rd_ptr, and count SHALL be 0; empty=1; full=0; rd_valid=0; rd_data=0; overflow=0; underflow=0.
REQ-027 Requests present in a reset cycle SHALL be ignored, and reset mid-operation SHALL discard all queued words.
REQ-028 RAM contents SHALL NOT be reset, and no stale word SHALL be observable after reset.

Structure
REQ-029 DATA_W, ADDR_W, and DEPTH defaults SHALL live in shared package ram_fifo_pkg.
REQ-030 Storage SHALL be one sub-module, ram_tdp_core: a DEPTH x DATA_W true dual-port RAM with port A as write-only (the push side), port B as read-only (the pop side), registered read-first output, and no reset.
REQ-031 Pointer, count, and flag control SHALL reside in ram_tdp_fifo; no other sub-modules.

Verification
REQ-032 Reset, then push 0x11,0x22,0x33 and pop 3 -> rd_data 0x11,0x22,0x33 each one cycle after its pop, rd_valid pulses 3 times, and empty=1 at the end.
REQ-033 Push 64 words 0x00..0x3F, then push 0xAA -> full=1, count=64, overflow pulses once, and 0xAA is never read.
REQ-034 From full, push 0x55 and pop simultaneously -> rd_data=0x00 (old word), count stays 64, and after 64 further pops the last word is 0x55.
REQ-035 From empty, push 0x77 and pop simultaneously -> underflow=1, count=1, and the next pop returns 0x77.
REQ-036 Fill to 40, pop 40, then push/pop 100 words crossing the wrap -> in-order data and count never exceeds bounds.
REQ-037 Assert rst_n=0 with count=10 for one cycle -> count=0, empty=1, and a subsequent pop gives underflow with no rd_valid.

Source files
------------

// File: rtl/ram_fifo_pkg.sv
// rtl/ram_fifo_pkg.sv - shared defaults and pointer helper for the TDP-RAM FIFO
package ram_fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DEPTH  = 64;

  // Advance a ring pointer, wrapping DEPTH-1 back to 0 even for non-power-of-2 depths.
  function automatic int wrap_inc(input int ptr, input int depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/ram_tdp_core.sv
// rtl/ram_tdp_core.sv - DEPTH x DATA_W dual-port RAM, write-only port A, read-first registered port B
module ram_tdp_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din_a,
  input  logic              en_b,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] dout_b
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= din_a;
  end

  // Same-edge read of the address being written returns the old word.
  always_ff @(posedge clk) begin
    if (en_b) dout_b <= mem[addr_b];
  end

endmodule

// File: rtl/ram_tdp_fifo.sv
// rtl/ram_tdp_fifo.sv - synchronous FIFO over a true dual-port RAM with occupancy and error pulses
module ram_tdp_fifo
  import ram_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_next;
  logic              wr_acc;
  logic              rd_acc;
  logic              rd_seen;
  logic [DATA_W-1:0] ram_q;

  always_comb begin
    wr_acc     = wr_en && (!full || rd_en);
    rd_acc     = rd_en && !empty;
    count_next = count + {{ADDR_W{1'b0}}, wr_acc} - {{ADDR_W{1'b0}}, rd_acc};
  end

  ram_tdp_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk    (clk),
    .we_a   (wr_acc && rst_n),
    .addr_a (wr_ptr),
    .din_a  (wr_data),
    .en_b   (rd_acc && rst_n),
    .addr_b (rd_ptr),
    .dout_b (ram_q)
  );

  // The RAM output register is never reset, so mask it until a pop has happened since reset.
  assign rd_data = rd_seen ? ram_q : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      rd_seen   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ADDR_W'(wrap_inc(32'(wr_ptr), DEPTH));
      if (rd_acc) rd_ptr <= ADDR_W'(wrap_inc(32'(rd_ptr), DEPTH));
      if (rd_acc) rd_seen <= 1'b1;
      count     <= count_next;
      full      <= (count_next == DEPTH_C);
      empty     <= (count_next == '0);
      rd_valid  <= rd_acc;
      overflow  <= wr_en && !wr_acc;
      underflow <= rd_en && !rd_acc;
    end
  end

endmodule

// File: tb/tb_ram_tdp_fifo.sv
// tb/tb_ram_tdp_fifo.sv - directed self-checking bench for ram_tdp_fifo
module tb_ram_tdp_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic [6:0] count;
  logic       overflow;
  logic       underflow;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] model_q[$];
  logic [7:0] exp_word;
  int pulses;
  int max_count;

  ram_tdp_fifo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of requests; outputs are sampled 1ns after the edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    wr_en = w; wr_data = d; rd_en = r;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b1; wr_data = 8'hEE; rd_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_underflow", underflow, 0);
    wr_en = 1'b0; rd_en = 1'b0;
    rst_n = 1'b1;
    step(0, 0, 0);

    // basic push/pop ordering
    step(1, 8'h11, 0);
    step(1, 8'h22, 0);
    step(1, 8'h33, 0);
    check("basic_count3", count, 3);
    pulses = 0;
    step(0, 0, 1); pulses += int'(rd_valid); check("basic_d0", rd_data, 8'h11);
    step(0, 0, 1); pulses += int'(rd_valid); check("basic_d1", rd_data, 8'h22);
    step(0, 0, 1); pulses += int'(rd_valid); check("basic_d2", rd_data, 8'h33);
    step(0, 0, 0); pulses += int'(rd_valid);
    check("basic_pulses", pulses, 3);
    check("basic_hold", rd_data, 8'h33);
    check("basic_empty", empty, 1);

    // fill to full, then rejected push
    for (int i = 0; i < 64; i++) step(1, 8'(i), 0);
    check("fill_full", full, 1);
    check("fill_count", count, 64);
    step(1, 8'hAA, 0);
    check("ovf_pulse", overflow, 1);
    check("ovf_count", count, 64);
    step(0, 0, 0);
    check("ovf_clear", overflow, 0);

    // simultaneous push/pop while full: read-first
    step(1, 8'h55, 1);
    check("full_rw_valid", rd_valid, 1);
    check("full_rw_data", rd_data, 8'h00);
    check("full_rw_count", count, 64);
    check("full_rw_full", full, 1);
    for (int i = 1; i < 65; i++) begin
      step(0, 0, 1);
      exp_word = (i == 64) ? 8'h55 : 8'(i);
      check($sformatf("drain_%0d", i), rd_data, exp_word);
    end
    check("drain_empty", empty, 1);
    check("drain_count", count, 0);

    // simultaneous push/pop while empty: only push accepted
    step(1, 8'h77, 1);
    check("empty_rw_underflow", underflow, 1);
    check("empty_rw_count", count, 1);
    check("empty_rw_valid", rd_valid, 0);
    check("empty_rw_empty", empty, 0);
    step(0, 0, 1);
    check("empty_rw_pop", rd_data, 8'h77);
    check("empty_rw_underflow_clr", underflow, 0);

    // fill 40, drain 40, then stream 100 words across the wrap
    for (int i = 0; i < 40; i++) begin
      step(1, 8'(8'h40 + i), 0);
      model_q.push_back(8'(8'h40 + i));
    end
    check("wrap_count40", count, 40);
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 1);
      exp_word = model_q.pop_front();
      check($sformatf("wrap_pre_%0d", i), rd_data, exp_word);
    end
    max_count = 0;
    step(1, 8'h80, 0);
    model_q.push_back(8'h80);
    for (int i = 1; i < 100; i++) begin
      step(1, 8'(8'h80 + i), 1);
      model_q.push_back(8'(8'h80 + i));
      exp_word = model_q.pop_front();
      check($sformatf("wrap_%0d", i), rd_data, exp_word);
      if (int'(count) > max_count) max_count = int'(count);
    end
    step(0, 0, 1);
    exp_word = model_q.pop_front();
    check("wrap_last", rd_data, exp_word);
    check("wrap_max_count", max_count, 1);
    check("wrap_empty", empty, 1);

    // reset mid-operation discards queued words
    for (int i = 0; i < 10; i++) step(1, 8'(8'hC0 + i), 0);
    check("mid_count10", count, 10);
    rst_n = 1'b0; rd_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; rd_en = 1'b0;
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_rd_data", rd_data, 0);
    step(0, 0, 1);
    check("mid_pop_underflow", underflow, 1);
    check("mid_pop_valid", rd_valid, 0);
    check("mid_pop_data", rd_data, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
